ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- PS/2 device-to-host receiver.
- Synchronises and debounces the raw ps2c/ps2d lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and checks parity, stop bit and inter-edge timeout.
- Delivers each valid scan code as dout plus a one-cycle rx_done_tick.
- Sits directly upstream of the keyboard scan-code FSM: dout feeds its scan_data input, rx_done_tick feeds its scan_done input.

Parameters:
- FILTER_LEN, 8, number of consecutive equal synchronised ps2c samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between filtered falling edges inside a frame (1 ms at 100 MHz) before the frame is aborted.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_en  input  1  enables detection of a new start bit.
- ps2c  input  1  raw PS/2 clock line (asynchronous).
- ps2d  input  1  raw PS/2 data line (asynchronous).
- dout  output  8  last valid scan code received.
- rx_done_tick  output  1  one-cycle pulse: dout has just been updated with a valid frame.
- parity_err  output  1  one-cycle pulse: frame dropped due to parity mismatch.
- frame_err  output  1  one-cycle pulse: frame dropped due to stop bit = 0 or timeout.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async) values:
  - dout=8'h00; rx_done_tick, parity_err, frame_err, busy = 0.
  - State = idle; shift register, bit counter and timeout counter cleared.
  - Filter history set to all-ones, filtered clock = 1.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-FF synchroniser.
  - Filter: shift register of FILTER_LEN synced ps2c samples. Filtered clock goes to 1 when all samples are 1, to 0 when all are 0, otherwise holds its value.
  - fall_tick = filtered clock 1 -> 0 (one cycle).
  - ps2d is sampled (synced) on fall_tick.
- FSM states: idle, rx (data/parity/stop), check.
  - idle: on fall_tick with rx_en=1 and ps2d=0 -> rx, bit counter n=9, timeout counter cleared. fall_tick with ps2d=1, or with rx_en=0, is ignored.
  - rx: each fall_tick shifts ps2d into a 10-bit shift register (right shift, MSB in) and reloads the timeout counter. n decrements. A fall_tick at n=0 (stop bit) -> check.
  - rx: when the timeout counter reaches TIMEOUT_CYCLES-1 with no fall_tick -> idle, frame_err pulses, no tick, dout unchanged.
  - check (exactly one cycle, always -> idle), with data = sr[7:0], par = sr[8], stop = sr[9]:
    - stop=0: frame_err=1.
    - else if ^{data,par}==0: parity_err=1.
    - else: dout<=data and rx_done_tick=1.
  - Error pulses and rx_done_tick are mutually exclusive; at most one pulse per frame.
- busy = 1 in rx and check.
- rx_en deasserted mid-frame does not abort; the current frame completes normally.
- All outputs are registered.
- Latency: rx_done_tick asserts no later than 2+FILTER_LEN+2 clk cycles after the raw 11th ps2c falling edge.
- dout holds its value between ticks.
- A new start edge during check is not possible (minimum PS/2 bit period >> 1 cycle); no queuing is provided.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encodings.
  - PS2_FRAME_BITS=11.
  - Scan-code constants BREAK=8'hF0, SHIFT1=8'h12, SHIFT2=8'h59, CAPS=8'h58 (shared with the keyboard FSM).
- One sub-module, ps2_clk_filter: 2-FF sync plus debounce plus fall_tick generation, parameterised by FILTER_LEN.

Test Plan:
Bench settings: TIMEOUT_CYCLES=2000, FILTER_LEN=8, ps2c half-period 40 clk, ps2d changed mid-high phase.
1. Frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> exactly one rx_done_tick, dout=8'h1C, no errors, busy drops after check.
2. Back-to-back 0xF0 (parity 1) then 0x12 (parity 1) -> two ticks in order, dout=8'hF0 then 8'h12.
3. 0x1C sent with parity bit 1 -> parity_err single pulse, no tick, dout retains previous value.
4. Start bit plus 4 data bits, then ps2c held high for 2500 clk -> frame_err pulse about 2000 cycles after the last edge, state idle. A following 0x58 frame (parity 0) -> tick, dout=8'h58.
5. 3-cycle low glitch on ps2c mid-bit during 0x33 frame -> glitch ignored, dout=8'h33. rx_en=0 at a start bit -> no busy, no tick.
6. Reset asserted after the 5th bit of a frame -> all outputs 0 immediately. Deassert reset; next full 0x1C frame -> tick, dout=8'h1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame geometry and the scan codes
// that the downstream keyboard FSM also decodes.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] SHIFT1 = 8'h12;
    localparam logic [7:0] SHIFT2 = 8'h59;
    localparam logic [7:0] CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK
    } rx_state_e;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// PS/2 line inputs and decoded scan-code outputs of the frame receiver.
interface ps2_rx_frame_if;

    logic       rx_en;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_en, ps2c, ps2d,
        input  dout, rx_done_tick, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_en, ps2c, ps2d,
        output dout, rx_done_tick, parity_err, frame_err, busy
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2c/ps2d, debounces ps2c over FILTER_LEN samples and flags the
// filtered falling edge together with the synchronised data bit.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic fall_tick_o,
    output logic ps2d_o
);

    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  fc_q;
    logic                  fc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            hist_q   <= '1;
            fc_q     <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c_i};
            d_sync_q <= {d_sync_q[0], ps2d_i};
            hist_q   <= {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
            fc_q     <= fc_d;
        end
    end

    // Level only changes once the whole history agrees; mixed samples hold it.
    always_comb begin
        fc_d = fc_q;
        if (&hist_q) begin
            fc_d = 1'b1;
        end else if (~|hist_q) begin
            fc_d = 1'b0;
        end
    end

    assign fall_tick_o = fc_q & ~fc_d;
    assign ps2d_o      = d_sync_q[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/stop,
// with inter-edge timeout, and emits one registered pulse per frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset,
    ps2_rx_frame_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic fall_tick;
    logic ps2d_s;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2c_i      (bus.ps2c),
        .ps2d_i      (bus.ps2d),
        .fall_tick_o (fall_tick),
        .ps2d_o      (ps2d_s)
    );

    rx_state_e   state_q, state_d;
    logic [3:0]  n_q, n_d;
    logic [9:0]  sr_q, sr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]  dout_q, dout_d;
    logic        tick_q, tick_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            sr_q    <= '0;
            tmo_q   <= '0;
            dout_q  <= '0;
            tick_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sr_q    <= sr_d;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            tick_q  <= tick_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        sr_d    = sr_q;
        tmo_d   = tmo_q;
        dout_d  = dout_q;
        tick_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall_tick && bus.rx_en && !ps2d_s) begin
                    state_d = ST_RX;
                    n_d     = 4'(PS2_FRAME_BITS - 2);
                    tmo_d   = '0;
                end
            end
            ST_RX: begin
                // Start bit is not stored: 10 shifts leave stop in sr[9], parity in sr[8].
                if (fall_tick) begin
                    sr_d  = {ps2d_s, sr_q[9:1]};
                    tmo_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!sr_q[9]) begin
                    ferr_d = 1'b1;
                end else if (!odd_parity_ok(sr_q[7:0], sr_q[8])) begin
                    perr_d = 1'b1;
                end else begin
                    dout_d = sr_q[7:0];
                    tick_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = tick_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frames are driven as raw PS/2 waveforms and
// every result pulse is matched against the queue of expected outcomes.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int unsigned FL   = 8;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 40;

    localparam int EV_NONE = 0;
    localparam int EV_TICK = 1;
    localparam int EV_PERR = 2;
    localparam int EV_FERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_fall_cyc = 0;
    int   last_tick_cyc = 0;
    int   last_ferr_cyc = 0;
    int   ticks_seen    = 0;
    logic busy_seen     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int   obs;
        exp_t e;
        if (bus.busy) busy_seen = 1'b1;
        if (!reset && (bus.rx_done_tick || bus.parity_err || bus.frame_err)) begin
            obs = bus.rx_done_tick ? EV_TICK : (bus.parity_err ? EV_PERR : EV_FERR);
            chk("pulse_onehot", $countones({bus.rx_done_tick, bus.parity_err, bus.frame_err}), 1);
            if (bus.rx_done_tick) begin
                last_tick_cyc = cyc;
                ticks_seen++;
            end
            if (bus.frame_err) last_ferr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", obs, EV_NONE);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", obs, e.kind);
                if (obs == EV_TICK) chk("dout_at_tick", bus.dout, e.data);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                             input logic stop);
        return {stop, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    task automatic push_exp(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Bit 0 first; data changes mid-high phase, optional 3-cycle clock glitch.
    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) begin
                wait_clk(10);
                bus.ps2c = 1'b0;
                wait_clk(3);
                bus.ps2c = 1'b1;
                wait_clk(7);
            end else begin
                wait_clk(HALF / 2);
            end
            bus.ps2d = f[i];
            wait_clk(HALF / 2);
            bus.ps2c = 1'b0;
            last_fall_cyc = cyc;
            wait_clk(HALF);
            bus.ps2c = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic par_flip, input logic stop,
                             input int kind);
        push_exp(kind, d);
        send_bits(mk_frame(d, par_flip, stop), 11, -1);
        wait_clk(60);
    endtask

    initial begin
        int t0;
        int delta;

        reset    = 1'b1;
        bus.rx_en = 1'b1;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        wait_clk(5);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_tick", bus.rx_done_tick, 0);
        chk("rst_perr", bus.parity_err, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        wait_clk(5);

        // 1: single good frame, latency bound and busy behaviour
        busy_seen = 1'b0;
        t0 = ticks_seen;
        push_exp(EV_TICK, 8'h1C);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, -1);
        wait_clk(30);
        delta = last_tick_cyc - last_fall_cyc;
        chk("t1_ticks", ticks_seen - t0, 1);
        chk("t1_latency_ok", (delta >= 1 && delta <= 2 + FL + 2), 1);
        chk("t1_dout", bus.dout, 8'h1C);
        chk("t1_busy_seen", busy_seen, 1);
        chk("t1_busy_after", bus.busy, 0);

        // 2: back-to-back frames
        t0 = ticks_seen;
        send_byte(BREAK, 1'b0, 1'b1, EV_TICK);
        chk("t2_dout_f0", bus.dout, 8'hF0);
        send_byte(SHIFT1, 1'b0, 1'b1, EV_TICK);
        chk("t2_dout_12", bus.dout, 8'h12);
        chk("t2_ticks", ticks_seen - t0, 2);

        // 3: parity error keeps dout
        t0 = ticks_seen;
        send_byte(8'h1C, 1'b1, 1'b1, EV_PERR);
        chk("t3_dout_kept", bus.dout, 8'h12);
        chk("t3_no_tick", ticks_seen - t0, 0);

        // 4: truncated frame times out, then recovery
        push_exp(EV_FERR, 8'h00);
        send_bits(mk_frame(8'h0F, 1'b0, 1'b1), 5, -1);
        wait_clk(2500);
        delta = last_ferr_cyc - last_fall_cyc;
        chk("t4_tmo_window", (delta >= TMO + 5 && delta <= TMO + 20), 1);
        chk("t4_busy_idle", bus.busy, 0);
        chk("t4_dout_kept", bus.dout, 8'h12);
        send_byte(CAPS, 1'b0, 1'b1, EV_TICK);
        chk("t4_dout_58", bus.dout, 8'h58);

        // 5: clock glitch ignored; rx_en low blocks a start bit
        push_exp(EV_TICK, 8'h33);
        send_bits(mk_frame(8'h33, 1'b0, 1'b1), 11, 4);
        wait_clk(60);
        chk("t5_glitch_dout", bus.dout, 8'h33);
        bus.rx_en = 1'b0;
        wait_clk(5);
        busy_seen = 1'b0;
        t0 = ticks_seen;
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 11, -1);
        wait_clk(60);
        chk("t5_rxen_busy", busy_seen, 0);
        chk("t5_rxen_ticks", ticks_seen - t0, 0);
        chk("t5_rxen_dout", bus.dout, 8'h33);
        bus.rx_en = 1'b1;
        wait_clk(10);

        // 6: asynchronous reset mid-frame
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, -1);
        wait_clk(10);
        chk("t6_busy_pre", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_dout", bus.dout, 8'h00);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_tick", bus.rx_done_tick, 0);
        chk("t6_rst_errs", {bus.parity_err, bus.frame_err}, 0);
        bus.ps2d = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        send_byte(8'h1C, 1'b0, 1'b1, EV_TICK);
        chk("t6_dout", bus.dout, 8'h1C);

        wait_clk(50);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
